easy_fifo_axis_pkt: RTL and testbench

EASY_FIFO_AXIS_PKT -- requirements
Module: easy_fifo_axis_pkt

---
 rtl/easy_fifo_axis_pkt.sv | 161 ++++++++++++++++
 tb/tb_easy_fifo_axis_pkt.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easy_fifo_axis_pkt.sv
// AXI-Stream FIFO with optional store-and-forward packet mode and bad-packet drop.
// Speculative write pointer, committed pointer and read pointer share one memory.
module easy_fifo_axis_pkt #(
    parameter int DWIDTH        = 32,
    parameter int DEPTH         = 16,
    parameter int PKT_MODE      = 1,
    parameter int DROP_EN       = 1,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [CW-1:0]     wr_count,
    output logic [CW-1:0]     rd_count,
    output logic [CW-1:0]     pkt_count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              drop_pulse
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    typedef enum logic {
        ST_ACCEPT,
        ST_DROP
    } wr_state_e;

    wr_state_e       r_state;
    wr_state_e       w_state_nxt;
    logic [CW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_cm_ptr;
    logic [CW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_pkt_count;
    logic [CW-1:0]   w_wr_ptr_nxt;
    logic [CW-1:0]   w_cm_ptr_nxt;
    logic [CW-1:0]   w_used;
    logic            r_ready_en;
    logic            r_drop_pulse;
    logic            w_has_room;
    logic            w_wr_fire;
    logic            w_rd_fire;
    logic            w_mem_we;
    logic            w_drop;
    logic            w_commit_pkt;
    logic [DWIDTH:0] w_rd_word;
    logic [DWIDTH:0] r_mem [DEPTH];

    assign w_used        = r_wr_ptr - r_rd_ptr;
    assign w_has_room    = w_used < DEPTH_C;
    // Ready is held low until the first edge after reset release.
    assign s_axis_tready = r_ready_en & ((r_state == ST_DROP) | w_has_room);
    assign w_wr_fire     = s_axis_tvalid & s_axis_tready;
    assign w_rd_word     = r_mem[r_rd_ptr[AW-1:0]];
    assign m_axis_tvalid = r_rd_ptr != r_cm_ptr;
    assign m_axis_tdata  = w_rd_word[DWIDTH-1:0];
    assign m_axis_tlast  = w_rd_word[DWIDTH];
    assign w_rd_fire     = m_axis_tvalid & m_axis_tready;

    assign wr_count      = w_used;
    assign rd_count      = r_cm_ptr - r_rd_ptr;
    assign pkt_count     = r_pkt_count;
    assign almost_full   = wr_count >= AFULL_C;
    assign almost_empty  = rd_count <= AEMPTY_C;
    assign drop_pulse    = r_drop_pulse;

    // NOTE: defaults first so every path assigns each signal and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_cm_ptr_nxt = r_cm_ptr;
        w_mem_we     = 1'b0;
        w_drop       = 1'b0;
        w_commit_pkt = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_wr_fire) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (PKT_MODE == 0) begin
                        w_cm_ptr_nxt = r_wr_ptr + 1'b1;
                        w_commit_pkt = s_axis_tlast;
                    end else if (s_axis_tlast) begin
                        if ((DROP_EN != 0) && s_axis_tuser) begin
                            w_wr_ptr_nxt = r_cm_ptr;
                            w_drop       = 1'b1;
                        end else begin
                            w_cm_ptr_nxt = r_wr_ptr + 1'b1;
                            w_commit_pkt = 1'b1;
                        end
                    end
                end else if ((PKT_MODE != 0) && !w_has_room &&
                             (r_wr_ptr != r_cm_ptr) && (r_cm_ptr == r_rd_ptr)) begin
                    // Packet larger than the whole FIFO can never commit: discard it.
                    w_wr_ptr_nxt = r_cm_ptr;
                    w_drop       = 1'b1;
                    w_state_nxt  = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_wr_fire && s_axis_tlast) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_cm_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_drop_pulse <= 1'b0;
            r_ready_en   <= 1'b0;
        end else begin
            r_ready_en   <= 1'b1;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_cm_ptr     <= w_cm_ptr_nxt;
            r_drop_pulse <= w_drop;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_commit_pkt, w_rd_fire & w_rd_word[DWIDTH]})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_easy_fifo_axis_pkt.sv
// Scoreboard bench: store-and-forward instance (defaults) plus a cut-through instance.
// Drivers push expected beats; negedge monitors pop and compare on every handshake.
module tb_easy_fifo_axis_pkt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [4:0]  wr_count, rd_count, pkt_count;
    logic        almost_full, almost_empty, drop_pulse;

    logic [31:0] c_tdata;
    logic        c_tvalid, c_tlast, c_tuser, c_tready;
    logic [31:0] c_m_tdata;
    logic        c_m_tvalid, c_m_tlast, c_m_tready;
    logic [4:0]  c_wr_count, c_rd_count, c_pkt_count;
    logic        c_almost_full, c_almost_empty, c_drop_pulse;

    int          total = 0;
    int          bad = 0;
    int          drop_seen = 0;
    int          ct_drop_seen = 0;
    int          exp_drops = 0;
    int          rdy_mode = 0;
    logic        rdy_fixed = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] ct_q[$];
    logic [32:0] mon_w, ct_w, hold_w;
    logic        hold_v = 1'b0;
    int          mon_n;

    easy_fifo_axis_pkt u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .wr_count(wr_count), .rd_count(rd_count), .pkt_count(pkt_count),
        .almost_full(almost_full), .almost_empty(almost_empty), .drop_pulse(drop_pulse)
    );

    easy_fifo_axis_pkt #(.PKT_MODE(0)) u_dut_ct (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tlast(c_tlast),
        .s_axis_tuser(c_tuser), .s_axis_tready(c_tready),
        .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tlast(c_m_tlast),
        .m_axis_tready(c_m_tready),
        .wr_count(c_wr_count), .rd_count(c_rd_count), .pkt_count(c_pkt_count),
        .almost_full(c_almost_full), .almost_empty(c_almost_empty), .drop_pulse(c_drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read-ready generator for the main instance: fixed level or 50% random.
    always @(posedge clk) begin
        #2;
        m_tready = (rdy_mode != 0) ? ($urandom_range(0, 1) == 1) : rdy_fixed;
    end

    // Main monitor: packet-count bound, hold stability, and beat comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            mon_n = 0;
            foreach (exp_q[i]) if (exp_q[i][32]) mon_n++;
            check("pkt_le_stored", 64'(pkt_count <= mon_n), 1);
            if (hold_v && m_tvalid) check("hold_stable", {m_tlast, m_tdata}, hold_w);
            hold_v = m_tvalid && !m_tready;
            hold_w = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h want none (t=%0t)", {m_tlast, m_tdata}, $time);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("rd_beat", {m_tlast, m_tdata}, mon_w);
                end
            end
            if (drop_pulse) drop_seen++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (c_m_tvalid && c_m_tready) begin
                if (ct_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ct_unexpected_out: got %0h want none", {c_m_tlast, c_m_tdata});
                end else begin
                    ct_w = ct_q.pop_front();
                    check("ct_rd_beat", {c_m_tlast, c_m_tdata}, ct_w);
                end
            end
            if (c_drop_pulse) ct_drop_seen++;
        end
    end

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic u, output int stalls);
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (!s_tready && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_tready) begin
            total++;
            bad++;
            $display("FAIL wr_timeout: s_axis_tready got 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input logic bad_pkt,
                            input bit gaps, input bit rnd);
        logic [32:0] beats[$];
        logic [31:0] d;
        int st;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            d = rnd ? $urandom : base + 32'(i);
            send_beat(d, i == len - 1, bad_pkt && (i == len - 1), st);
            beats.push_back({i == len - 1, d});
        end
        s_tvalid = 1'b0;
        if (bad_pkt) exp_drops++;
        else foreach (beats[k]) exp_q.push_back(beats[k]);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, d0, e0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        c_tdata = '0; c_tvalid = 1'b0; c_tlast = 1'b0; c_tuser = 1'b0; c_m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_tready", s_tready, 0);
        check("rst_ct_tready", c_tready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tready_pre", s_tready, 0);
        @(posedge clk);
        #1;
        check("rel_tready_post", s_tready, 1);

        // 4-beat packet, store-and-forward latency
        rdy_fixed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hA000_0000 + 32'(i), i == 3, 1'b0, st);
            if (i < 3) check("sf_no_early_valid", m_tvalid, 0);
        end
        s_tvalid = 1'b0;
        check("sf_valid_after_last", m_tvalid, 1);
        check("sf_pkt_count_1", pkt_count, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 32'hA000_0000 + 32'(i)});
        wait_drain(50);
        check("sf_pkt_count_0", pkt_count, 0);

        // bad packet drop
        d0 = drop_seen;
        send_pkt(3, 32'hB000_0000, 1'b1, 1'b0, 1'b0);
        check("bad_wr_count", wr_count, 0);
        check("bad_drop_hi", drop_pulse, 1);
        @(posedge clk);
        #1;
        check("bad_drop_lo", drop_pulse, 0);
        idle(3);
        check("bad_drop_once", drop_seen - d0, 1);
        check("bad_no_valid", m_tvalid, 0);

        // oversize packet with reads blocked
        rdy_fixed = 1'b0;
        idle(1);
        d0 = drop_seen;
        for (int i = 0; i < 20; i++) begin
            send_beat(32'hC000_0000 + 32'(i), i == 19, 1'b0, st);
            if (i == 15) begin
                check("ovr_wr_count16", wr_count, 16);
                check("ovr_afull", almost_full, 1);
                check("ovr_rd_count0", rd_count, 0);
            end
            if (i == 16) begin
                check("ovr_drop", drop_seen - d0, 1);
                check("ovr_rewind", wr_count, 0);
            end
            if (i > 16) check("ovr_drop_ready", st, 0);
        end
        idle(2);
        check("ovr_drop_once", drop_seen - d0, 1);
        send_pkt(2, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
        check("ovr_next_rd_count", rd_count, 2);
        check("ovr_next_pkt", pkt_count, 1);
        rdy_fixed = 1'b1;
        wait_drain(50);

        // cut-through fill to full, tuser on tlast must be ignored
        c_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c_tdata = 32'hE000_0000 + 32'(i);
            c_tlast = (i == 15);
            c_tuser = (i == 15);
            @(posedge clk);
            #1;
            ct_q.push_back({i == 15, 32'hE000_0000 + 32'(i)});
            if (i == 0) check("ct_latency", c_m_tvalid, 1);
        end
        c_tvalid = 1'b0;
        check("ct_full_tready", c_tready, 0);
        check("ct_wr_count16", c_wr_count, 16);
        check("ct_rd_count16", c_rd_count, 16);
        check("ct_afull", c_almost_full, 1);
        check("ct_pkt_count", c_pkt_count, 1);
        c_m_tready = 1'b1;
        @(posedge clk);
        #1;
        c_m_tready = 1'b0;
        check("ct_tready_after_rd", c_tready, 1);
        check("ct_wr_count15", c_wr_count, 15);
        c_m_tready = 1'b1;
        for (int n = 0; n < 60 && ct_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        c_m_tready = 1'b0;
        check("ct_drained", ct_q.size(), 0);
        check("ct_pkt_count0", c_pkt_count, 0);
        check("ct_wr_count0", c_wr_count, 0);
        check("ct_aempty", c_almost_empty, 1);
        check("ct_no_drop", ct_drop_seen, 0);

        // random traffic, 1000 packets
        rdy_mode = 1;
        d0 = drop_seen;
        e0 = exp_drops;
        for (int p = 0; p < 1000; p++) begin
            send_pkt($urandom_range(1, 8), 32'h0, $urandom_range(0, 7) == 0, 1'b1, 1'b1);
        end
        wait_drain(2000);
        check("rnd_drops", drop_seen - d0, exp_drops - e0);
        check("rnd_pkt_count0", pkt_count, 0);
        check("rnd_wr_count0", wr_count, 0);
        rdy_mode = 0;
        rdy_fixed = 1'b0;
        idle(2);

        // reset mid-packet with 5 committed entries
        send_pkt(5, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        send_beat(32'hF100_0000, 1'b0, 1'b0, st);
        send_beat(32'hF100_0001, 1'b0, 1'b0, st);
        check("mid_rd_count5", rd_count, 5);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("mid_tvalid", m_tvalid, 0);
        check("mid_wr_count", wr_count, 0);
        check("mid_rd_count", rd_count, 0);
        check("mid_pkt_count", pkt_count, 0);
        check("mid_tready", s_tready, 0);
        exp_q.delete();
        ct_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_pre", s_tready, 0);
        @(posedge clk);
        #1;
        check("mid_rel_post", s_tready, 1);
        send_pkt(3, 32'h9000_0000, 1'b0, 1'b0, 1'b0);
        rdy_fixed = 1'b1;
        wait_drain(50);
        check("mid_pkt_count0", pkt_count, 0);

        check("final_exp_q", exp_q.size(), 0);
        check("final_ct_q", ct_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
